stop_watch_counter: RTL and testbench

Time-value datapath for the stopwatch. Holds four BCD fields (centiseconds, seconds, minutes, hours) and steps each one on the per-field up/down strobes from the stopwatch control stage. Drives terminal-value flags back to that control stage so it can ripple increments. Also feeds the display path directly with packed BCD digits.

---
 rtl/stop_watch_pkg.sv | 21 ++
 rtl/stop_watch_bcd_field.sv | 86 ++++++++
 rtl/stop_watch_counter.sv | 67 ++++++
 tb/tb_stop_watch_counter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/stop_watch_pkg.sv
// Shared constants and helpers for the stopwatch time-value datapath.
// Provides default moduli, BCD widths and the terminal-code builder.
package stop_watch_pkg;

  localparam int MS_MOD_DEF  = 100;
  localparam int SEC_MOD_DEF = 60;
  localparam int MIN_MOD_DEF = 60;
  localparam int HR_MOD_DEF  = 24;

  localparam int BCD_W = 8;
  localparam int DIG_W = 4;

  function automatic logic [BCD_W-1:0] to_bcd8(input int v);
    logic [DIG_W-1:0] t;
    logic [DIG_W-1:0] o;
    t = DIG_W'(v / 10);
    o = DIG_W'(v % 10);
    return {t, o};
  endfunction

endpackage

// File: rtl/stop_watch_bcd_field.sv
// One two-digit BCD field with up/down/clear stepping modulo MOD.
// Carry flag marks the terminal value MOD-1 of the registered state.
module stop_watch_bcd_field
  import stop_watch_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_up,
  input  logic             i_down,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_carryup
);

  localparam logic [BCD_W-1:0] TERM = to_bcd8(MOD - 1);

  logic [DIG_W-1:0] tens;
  logic [DIG_W-1:0] ones;
  logic [DIG_W-1:0] tens_nx;
  logic [DIG_W-1:0] ones_nx;
  logic [BCD_W-1:0] bin;
  logic             valid;
  logic             at_term;
  logic             at_zero;
  logic             clr;
  logic             inc;
  logic             dec;

  assign clr = i_up & i_down;
  assign inc = i_up & ~i_down;
  assign dec = ~i_up & i_down;

  assign bin = BCD_W'(tens) * BCD_W'(10) + BCD_W'(ones);
  // Non-BCD or out-of-range codes fall back onto the wrap path
  assign valid   = (ones <= DIG_W'(9)) && (bin < BCD_W'(MOD));
  assign at_term = ({tens, ones} == TERM);
  assign at_zero = ({tens, ones} == '0);

  always_comb begin
    tens_nx = tens;
    ones_nx = ones;
    unique case (1'b1)
      clr: begin
        tens_nx = '0;
        ones_nx = '0;
      end
      inc: begin
        if (!valid || at_term) begin
          tens_nx = '0;
          ones_nx = '0;
        end else if (ones == DIG_W'(9)) begin
          tens_nx = tens + DIG_W'(1);
          ones_nx = '0;
        end else begin
          ones_nx = ones + DIG_W'(1);
        end
      end
      dec: begin
        if (!valid || at_zero) begin
          {tens_nx, ones_nx} = TERM;
        end else if (ones == '0) begin
          tens_nx = tens - DIG_W'(1);
          ones_nx = DIG_W'(9);
        end else begin
          ones_nx = ones - DIG_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tens <= '0;
      ones <= '0;
    end else begin
      tens <= tens_nx;
      ones <= ones_nx;
    end
  end

  assign o_bcd     = {tens, ones};
  assign o_carryup = at_term;

endmodule

// File: rtl/stop_watch_counter.sv
// Stopwatch time-value datapath: four independent BCD fields.
// Cascading is done outside by gating up strobes with carry flags.
module stop_watch_counter
  import stop_watch_pkg::*;
#(
  parameter int MS_MOD  = MS_MOD_DEF,
  parameter int SEC_MOD = SEC_MOD_DEF,
  parameter int MIN_MOD = MIN_MOD_DEF,
  parameter int HR_MOD  = HR_MOD_DEF
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_ms_up,
  input  logic             i_ms_down,
  input  logic             i_sec_up,
  input  logic             i_sec_down,
  input  logic             i_min_up,
  input  logic             i_min_down,
  input  logic             i_hr_up,
  input  logic             i_hr_down,
  output logic [BCD_W-1:0] o_ms_bcd,
  output logic [BCD_W-1:0] o_sec_bcd,
  output logic [BCD_W-1:0] o_min_bcd,
  output logic [BCD_W-1:0] o_hr_bcd,
  output logic             o_ms_carryup,
  output logic             o_sec_carryup,
  output logic             o_min_carryup,
  output logic             o_hr_carryup
);

  stop_watch_bcd_field #(.MOD(MS_MOD)) u_ms (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_up      (i_ms_up),
    .i_down    (i_ms_down),
    .o_bcd     (o_ms_bcd),
    .o_carryup (o_ms_carryup)
  );

  stop_watch_bcd_field #(.MOD(SEC_MOD)) u_sec (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_up      (i_sec_up),
    .i_down    (i_sec_down),
    .o_bcd     (o_sec_bcd),
    .o_carryup (o_sec_carryup)
  );

  stop_watch_bcd_field #(.MOD(MIN_MOD)) u_min (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_up      (i_min_up),
    .i_down    (i_min_down),
    .o_bcd     (o_min_bcd),
    .o_carryup (o_min_carryup)
  );

  stop_watch_bcd_field #(.MOD(HR_MOD)) u_hr (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_up      (i_hr_up),
    .i_down    (i_hr_down),
    .o_bcd     (o_hr_bcd),
    .o_carryup (o_hr_carryup)
  );

endmodule

// File: tb/tb_stop_watch_counter.sv
// Self-checking bench for stop_watch_counter.
// Decimal reference model feeds an expected-value queue per step.
module tb_stop_watch_counter;

  typedef struct {
    logic [7:0] bcd [4];
    logic       cry [4];
  } exp_t;

  logic       clk;
  logic       rstn;
  logic [3:0] up;
  logic [3:0] dn;
  logic [7:0] ms_bcd, sec_bcd, min_bcd, hr_bcd;
  logic       ms_c, sec_c, min_c, hr_c;

  int   mods [4] = '{100, 60, 60, 24};
  int   val  [4];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  string nm [4] = '{"ms", "sec", "min", "hr"};

  stop_watch_counter dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_ms_up       (up[0]),
    .i_ms_down     (dn[0]),
    .i_sec_up      (up[1]),
    .i_sec_down    (dn[1]),
    .i_min_up      (up[2]),
    .i_min_down    (dn[2]),
    .i_hr_up       (up[3]),
    .i_hr_down     (dn[3]),
    .o_ms_bcd      (ms_bcd),
    .o_sec_bcd     (sec_bcd),
    .o_min_bcd     (min_bcd),
    .o_hr_bcd      (hr_bcd),
    .o_ms_carryup  (ms_c),
    .o_sec_carryup (sec_c),
    .o_min_carryup (min_c),
    .o_hr_carryup  (hr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dec2bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.bcd[i] = dec2bcd(val[i]);
      e.cry[i] = (val[i] == mods[i] - 1);
    end
    return e;
  endfunction

  task automatic compare(input exp_t e, input string tag);
    logic [7:0] ab [4];
    logic       ac [4];
    ab = '{ms_bcd, sec_bcd, min_bcd, hr_bcd};
    ac = '{ms_c, sec_c, min_c, hr_c};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ab[i] !== e.bcd[i]) begin
        errors++;
        $display("FAIL %s %s_bcd got %h want %h", tag, nm[i], ab[i], e.bcd[i]);
      end
      checks++;
      if (ac[i] !== e.cry[i]) begin
        errors++;
        $display("FAIL %s %s_carry got %b want %b", tag, nm[i], ac[i], e.cry[i]);
      end
    end
  endtask

  // Drive one command vector, model it, then check after the edge
  task automatic step(input logic [3:0] u, input logic [3:0] d,
                      input string tag);
    exp_t e;
    up = u;
    dn = d;
    for (int i = 0; i < 4; i++) begin
      if (u[i] && d[i])  val[i] = 0;
      else if (u[i])     val[i] = (val[i] + 1) % mods[i];
      else if (d[i])     val[i] = (val[i] + mods[i] - 1) % mods[i];
    end
    sb.push_back(snap());
    @(posedge clk);
    #1;
    up = '0;
    dn = '0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty got 0 want 1", tag);
    end else begin
      e = sb.pop_front();
      compare(e, tag);
    end
  endtask

  task automatic clear_all();
    step(4'hF, 4'hF, "clear_all");
  endtask

  task automatic test_reset();
    exp_t e;
    rstn = 1'b0;
    up = '0;
    dn = '0;
    for (int i = 0; i < 4; i++) val[i] = 0;
    #3;
    compare(snap(), "reset_init");
    @(negedge clk);
    rstn = 1'b1;
    step(4'h0, 4'hF, "pre_reset");
    step(4'h1, 4'h0, "pre_reset2");
    #2;
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) val[i] = 0;
    #1;
    e = snap();
    compare(e, "reset_async");
    @(negedge clk);
    compare(e, "reset_hold");
    rstn = 1'b1;
  endtask

  task automatic test_ms_count();
    for (int k = 0; k < 100; k++) step(4'h1, 4'h0, "ms_count");
  endtask

  task automatic test_sec_carry();
    clear_all();
    step(4'h0, 4'h3, "sec_carry_setup");
    step(4'h3, 4'h0, "sec_carry_roll");
  endtask

  task automatic test_dec_wrap();
    clear_all();
    step(4'h0, 4'hF, "dec_wrap");
    step(4'h0, 4'hF, "dec_wrap2");
  endtask

  task automatic test_clear();
    clear_all();
    step(4'h0, 4'h6, "clear_setup");
    for (int k = 0; k < 47; k++) step(4'h1, 4'h0, "clear_to47");
    step(4'h1, 4'h1, "clear_at47");
    step(4'h2, 4'h2, "clear_at_term");
  endtask

  task automatic test_rollover();
    clear_all();
    step(4'h0, 4'hF, "roll_setup");
    step(4'hF, 4'h0, "roll_all");
    step(4'h1, 4'h0, "roll_ms1");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 300; k++)
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "b2b");
  endtask

  initial begin
    test_reset();
    test_ms_count();
    test_sec_carry();
    test_dec_wrap();
    test_clear();
    test_rollover();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
